// File: rtl/amci_pkg.sv
// rtl/amci_pkg.sv - shared AMCI field layout, width helpers, FSM states and AXI response codes
package amci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT1,
        ST_WAIT_DONE,
        ST_RESPOND
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // MOSI = {read, write, raddr, wdata, waddr}; MISO = {rresp, wresp, ridle, widle, rdata}
    localparam int MOSI_WADDR_OFS = 0;
    localparam int MISO_RDATA_OFS = 0;

    function automatic int mosi_wdata_ofs(input int aw);
        return aw;
    endfunction

    function automatic int mosi_raddr_ofs(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int mosi_write_ofs(input int aw, input int dw);
        return 2 * aw + dw;
    endfunction

    function automatic int mosi_read_ofs(input int aw, input int dw);
        return 2 * aw + dw + 1;
    endfunction

    function automatic int miso_widle_ofs(input int dw);
        return dw;
    endfunction

    function automatic int miso_ridle_ofs(input int dw);
        return dw + 1;
    endfunction

    function automatic int miso_wresp_ofs(input int dw);
        return dw + 2;
    endfunction

    function automatic int miso_rresp_ofs(input int dw);
        return dw + 4;
    endfunction

    function automatic int mosi_width(input int aw, input int dw);
        return 2 * aw + dw + 2;
    endfunction

    function automatic int miso_width(input int dw);
        return dw + 6;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amci_arbiter_rr_arbiter.sv
// rtl/amci_arbiter_rr_arbiter.sv - combinational round-robin next-grant search starting at ptr+1
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the farthest distance down so the nearest requester overwrites.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int d = N; d >= 1; d--) begin
            if (req[(int'(ptr) + d) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + d) % N);
            end
        end
    end

endmodule

// File: rtl/amci_arbiter.sv
// rtl/amci_arbiter.sv - round-robin multi-client AMCI master with completion pulses and timeout
module amci_arbiter
    import amci_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 0,
    localparam int AW = AXI_ADDR_WIDTH,
    localparam int DW = AXI_DATA_WIDTH,
    localparam int CW = idx_width(NUM_CH)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_CH-1:0]             ch_req,
    input  logic [NUM_CH-1:0]             ch_write,
    input  logic [NUM_CH*AW-1:0]          ch_addr,
    input  logic [NUM_CH*DW-1:0]          ch_wdata,
    output logic [NUM_CH-1:0]             ch_ack,
    output logic [DW-1:0]                 rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic [CW-1:0]                 grant_id,
    output logic [mosi_width(AW, DW)-1:0] AMCI_MOSI,
    input  logic [miso_width(DW)-1:0]     AMCI_MISO
);

    localparam int TW = idx_width(TIMEOUT + 1);

    state_t          state;
    logic [CW-1:0]   ptr;
    logic            lat_write;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic [DW-1:0]   wdata;
    logic            wr_stb;
    logic            rd_stb;
    logic [TW-1:0]   tmo_cnt;

    logic            rr_found;
    logic [CW-1:0]   rr_idx;

    logic [DW-1:0]   rdata;
    logic            widle;
    logic            ridle;
    logic [1:0]      wresp;
    logic [1:0]      rresp;
    logic            sel_idle;

    assign rdata    = AMCI_MISO[MISO_RDATA_OFS +: DW];
    assign widle    = AMCI_MISO[miso_widle_ofs(DW)];
    assign ridle    = AMCI_MISO[miso_ridle_ofs(DW)];
    assign wresp    = AMCI_MISO[miso_wresp_ofs(DW) +: 2];
    assign rresp    = AMCI_MISO[miso_rresp_ofs(DW) +: 2];
    assign sel_idle = lat_write ? widle : ridle;

    assign AMCI_MOSI[MOSI_WADDR_OFS +: AW]         = waddr;
    assign AMCI_MOSI[mosi_wdata_ofs(AW) +: DW]     = wdata;
    assign AMCI_MOSI[mosi_raddr_ofs(AW, DW) +: AW] = raddr;
    assign AMCI_MOSI[mosi_write_ofs(AW, DW)]       = wr_stb;
    assign AMCI_MOSI[mosi_read_ofs(AW, DW)]        = rd_stb;

    rr_arbiter #(
        .N (NUM_CH),
        .W (CW)
    ) u_rr (
        .req   (ch_req),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            ptr         <= CW'(NUM_CH - 1);
            grant_id    <= '0;
            lat_write   <= 1'b0;
            waddr       <= '0;
            raddr       <= '0;
            wdata       <= '0;
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
            tmo_cnt     <= '0;
            ch_ack      <= '0;
            rsp_data    <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant_id  <= rr_idx;
                        lat_write <= ch_write[rr_idx];
                        waddr     <= ch_write[rr_idx] ? ch_addr[rr_idx*AW +: AW] : '0;
                        raddr     <= ch_write[rr_idx] ? '0 : ch_addr[rr_idx*AW +: AW];
                        wdata     <= ch_write[rr_idx] ? ch_wdata[rr_idx*DW +: DW] : '0;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sel_idle) begin
                        wr_stb <= lat_write;
                        rd_stb <= ~lat_write;
                        state  <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    wr_stb  <= 1'b0;
                    rd_stb  <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // A genuine completion wins over a timeout landing in the same cycle.
                    if (sel_idle) begin
                        rsp_resp    <= lat_write ? wresp : rresp;
                        rsp_data    <= lat_write ? '0 : rdata;
                        rsp_timeout <= 1'b0;
                        ch_ack      <= NUM_CH'(1) << grant_id;
                        state       <= ST_RESPOND;
                    end else if (TIMEOUT > 0 && int'(tmo_cnt) == TIMEOUT - 1) begin
                        rsp_resp    <= RESP_SLVERR;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        ch_ack      <= NUM_CH'(1) << grant_id;
                        state       <= ST_RESPOND;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_RESPOND: begin
                    ch_ack      <= '0;
                    rsp_data    <= '0;
                    rsp_resp    <= '0;
                    rsp_timeout <= 1'b0;
                    ptr         <= grant_id;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amci_arbiter.sv
// tb/tb_amci_arbiter.sv - directed scoreboard bench for amci_arbiter with a behavioural bridge model
module tb_amci_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_write;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     rsp_data;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic              busy;
    logic [1:0]        grant_id;
    logic [2*AW+DW+1:0] AMCI_MOSI;
    logic [DW+5:0]     AMCI_MISO;

    logic          widle_m, ridle_m;
    logic [1:0]    wresp_m, rresp_m;
    logic [DW-1:0] rdata_m;
    assign AMCI_MISO = {rresp_m, wresp_m, ridle_m, widle_m, rdata_m};

    logic [AW-1:0] m_waddr, m_raddr;
    logic [DW-1:0] m_wdata;
    logic          m_wr, m_rd;
    assign m_waddr = AMCI_MOSI[31:0];
    assign m_wdata = AMCI_MOSI[63:32];
    assign m_raddr = AMCI_MOSI[95:64];
    assign m_wr    = AMCI_MOSI[96];
    assign m_rd    = AMCI_MOSI[97];

    amci_arbiter #(
        .NUM_CH         (NCH),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .TIMEOUT        (TMO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ch_req      (ch_req),
        .ch_write    (ch_write),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_ack      (ch_ack),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .grant_id    (grant_id),
        .AMCI_MOSI   (AMCI_MOSI),
        .AMCI_MISO   (AMCI_MISO)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acks = 0;
    int n_wstb = 0;
    int stb_cyc, ack_cyc, rise_cyc, c0, base, n;

    int            busy_m = 1;
    logic          hang = 1'b0;
    logic [DW-1:0] rdata_val = '0;
    logic [1:0]    rresp_val = 2'b00;
    logic [1:0]    wresp_val = 2'b00;
    logic          mdl_wr;

    typedef struct {
        int            ch;
        logic [1:0]    resp;
        logic [DW-1:0] data;
        logic          tmo;
    } exp_t;
    exp_t sb[$];
    exp_t e_mon;
    logic prev_ack_any = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [1:0] r, input logic [DW-1:0] d, input logic t);
        exp_t e;
        e.ch = ch; e.resp = r; e.data = d; e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic req(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_write[ch]         = wr;
        ch_addr[ch*AW +: AW]  = a;
        ch_wdata[ch*DW +: DW] = d;
        ch_req[ch]           = 1'b1;
    endtask

    task automatic wait_strobe(input logic wr, input int budget);
        int k = 0;
        while (!(wr ? m_wr : m_rd) && k < budget) begin @(negedge CLK); k++; end
        check("strobe_seen", wr ? m_wr : m_rd, 1'b1);
        stb_cyc = cyc;
    endtask

    task automatic wait_ack(input int ch, input int budget);
        int k = 0;
        while (!ch_ack[ch] && k < budget) begin @(negedge CLK); k++; end
        check("ack_seen", ch_ack[ch], 1'b1);
        ack_cyc = cyc;
        ch_req[ch] = 1'b0;
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Bridge model: drops the selected idle after a strobe, holds it for busy_m cycles (or while hang).
    initial forever begin
        @(posedge CLK); #1;
        if (m_wr === 1'b1 || m_rd === 1'b1) begin
            mdl_wr = m_wr;
            if (mdl_wr) widle_m = 1'b0; else ridle_m = 1'b0;
            repeat (busy_m) begin @(posedge CLK); #1; end
            while (hang) begin @(posedge CLK); #1; end
            if (mdl_wr) begin
                wresp_m = wresp_val;
                widle_m = 1'b1;
            end else begin
                rdata_m = rdata_val;
                rresp_m = rresp_val;
                ridle_m = 1'b1;
            end
            rise_cyc = cyc;
        end
    end

    // Output monitor and scoreboard consumer.
    initial forever begin
        @(negedge CLK);
        if (m_wr === 1'b1) begin
            n_wstb++;
            check("wr_strobe_1cyc", prev_wr, 1'b0);
        end
        if (m_rd === 1'b1) check("rd_strobe_1cyc", prev_rd, 1'b0);
        if (ch_ack !== '0) begin
            check("ack_onehot", $onehot(ch_ack), 1'b1);
            check("ack_1cyc", prev_ack_any, 1'b0);
            if (sb.size() == 0) begin
                check("ack_unexpected", ch_ack, 0);
            end else begin
                e_mon = sb.pop_front();
                check("ack_ch", ch_ack, 128'(1) << e_mon.ch);
                check("rsp_resp", rsp_resp, e_mon.resp);
                check("rsp_data", rsp_data, e_mon.data);
                check("rsp_timeout", rsp_timeout, e_mon.tmo);
            end
            n_acks++;
        end
        prev_wr      = (m_wr === 1'b1);
        prev_rd      = (m_rd === 1'b1);
        prev_ack_any = (ch_ack !== '0);
    end

    initial begin
        RESET = 1'b1;
        ch_req = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0;
        widle_m = 1'b1; ridle_m = 1'b1; wresp_m = 2'b00; rresp_m = 2'b00; rdata_m = '0;
        repeat (3) @(negedge CLK);
        check("rst_ack", ch_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_mosi", AMCI_MOSI, 0);
        check("rst_rsp", {rsp_data, rsp_resp, rsp_timeout}, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Single write on ch2
        busy_m = 1; wresp_val = 2'b00;
        push(2, 2'b00, '0, 1'b0);
        c0 = cyc;
        req(2, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_strobe(1'b1, 10);
        check("t1_strobe_latency", stb_cyc - c0, 2);
        check("t1_waddr", m_waddr, 32'h0000_1000);
        check("t1_wdata", m_wdata, 32'hDEAD_BEEF);
        check("t1_grant", grant_id, 2);
        check("t1_no_read", m_rd, 1'b0);
        wait_ack(2, 20);
        repeat (3) @(negedge CLK);

        // Read on ch0, five busy cycles
        busy_m = 5; rdata_val = 32'h1234_5678; rresp_val = 2'b00;
        push(0, 2'b00, 32'h1234_5678, 1'b0);
        req(0, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF);
        wait_strobe(1'b0, 10);
        check("t2_raddr", m_raddr, 32'h0000_0020);
        check("t2_no_write", m_wr, 1'b0);
        check("t2_grant", grant_id, 0);
        wait_ack(0, 30);
        check("t2_ack_after_ridle", ack_cyc - rise_cyc, 1);
        repeat (3) @(negedge CLK);

        // Reset in WAIT_DONE: no ack, outputs cleared asynchronously
        busy_m = 1; hang = 1'b1;
        req(1, 1'b1, 32'h44, 32'h55);
        wait_strobe(1'b1, 10);
        repeat (4) @(negedge CLK);
        check("t5_busy_before", busy, 1'b1);
        #2 RESET = 1'b1;
        #1;
        check("t5_async_busy", busy, 1'b0);
        check("t5_async_mosi", AMCI_MOSI, 0);
        check("t5_async_ack", ch_ack, 0);
        ch_req[1] = 1'b0;
        hang = 1'b0;
        repeat (3) @(negedge CLK);
        check("t5_no_ack", ch_ack, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // All four request continuously: ch0 first after reset, then strict rotation
        busy_m = 1;
        for (int i = 0; i < 8; i++) push(i % 4, 2'b00, '0, 1'b0);
        for (int i = 0; i < 4; i++) req(i, 1'b1, 32'h100 + i, 32'hA0 + i);
        base = n_acks; n = 0;
        while (n_acks < base + 8 && n < 200) begin @(negedge CLK); n++; end
        check("t3_eight_acks", n_acks - base, 8);
        ch_req = '0;
        repeat (3) @(negedge CLK);

        // Timeout: bridge never raises widle
        hang = 1'b1;
        push(1, 2'b10, '0, 1'b1);
        req(1, 1'b1, 32'h200, 32'h77);
        wait_strobe(1'b1, 10);
        wait_ack(1, 40);
        check("t4_timeout_cycles", ack_cyc - stb_cyc, 17);
        push(2, 2'b00, '0, 1'b0);
        base = n_wstb;
        req(2, 1'b1, 32'h300, 32'h88);
        repeat (10) @(negedge CLK);
        check("t4_stall_no_strobe", n_wstb - base, 0);
        check("t4_stall_busy", busy, 1'b1);
        check("t4_stall_grant", grant_id, 2);
        hang = 1'b0;
        wait_strobe(1'b1, 10);
        check("t4_waddr", m_waddr, 32'h300);
        wait_ack(2, 20);
        repeat (3) @(negedge CLK);

        // Slave error read on ch3, then rotation resumes at ch0
        busy_m = 2; rresp_val = 2'b10; rdata_val = 32'h0000_0BAD;
        push(3, 2'b10, 32'h0000_0BAD, 1'b0);
        req(3, 1'b0, 32'h400, '0);
        wait_ack(3, 30);
        rresp_val = 2'b00;
        @(negedge CLK);
        push(0, 2'b00, '0, 1'b0);
        push(1, 2'b00, '0, 1'b0);
        push(2, 2'b00, '0, 1'b0);
        busy_m = 1;
        req(2, 1'b1, 32'h502, 32'h2);
        req(1, 1'b1, 32'h501, 32'h1);
        req(0, 1'b1, 32'h500, 32'h0);
        wait_ack(0, 30);
        wait_ack(1, 30);
        wait_ack(2, 30);
        repeat (5) @(negedge CLK);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
